// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StError   = 2'd2
  } state_e;

  localparam int unsigned ZeroReg     = 0;
  localparam int unsigned DefaultRegW = 5;
  localparam int unsigned DefaultCntW = 16;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller: load-use bubbles, MEM-stage redirects, dmem wait holds.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned REG_W    = DefaultRegW,
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned CNT_W    = DefaultCntW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_write_reg,
  input  logic             mem_redirect,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_flush,
  output logic             front_hold,
  output logic             mw_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             load_use, run_dec, stall_inc, flush_inc;

  assign load_use = ex_mem_read && (ex_write_reg != REG_W'(ZeroReg)) &&
                    ((ex_write_reg == id_rs) || (id_uses_rt && (ex_write_reg == id_rt)));

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    run_dec     = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_flush = 1'b0;
    front_hold  = 1'b0;
    mw_bubble   = 1'b0;

    unique case (state_q)
      StRun: begin
        if (dmem_req && !dmem_ready) begin
          state_d   = StMemWait;
          wait_d    = WaitW'(1);
          stall_inc = 1'b1;
        end else begin
          run_dec = 1'b1;
        end
      end
      StMemWait: begin
        if (dmem_ready) begin
          state_d = StRun;
          wait_d  = '0;
          run_dec = 1'b1;
        end else begin
          stall_inc = 1'b1;
          if (wait_q == WaitW'(MAX_WAIT)) begin
            state_d = StError;
          end else begin
            wait_d = wait_q + WaitW'(1);
          end
        end
      end
      StError: ;
      default: state_d = StRun;
    endcase

    // Anything that is not decoding normally is holding the pipeline.
    if (!run_dec) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      front_hold = 1'b1;
      mw_bubble  = 1'b1;
    end else if (mem_redirect) begin
      pc_write    = 1'b1;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_flush = 1'b1;
      flush_inc   = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      stall_inc   = 1'b1;
    end

    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_flush = 1'b1;
      front_hold  = 1'b0;
      mw_bubble   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign mem_err = (state_q == StError);

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (stall_inc),
    .clr  (1'b0),
    .count(stall_count)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_flush_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (flush_inc),
    .clr  (1'b0),
    .count(flush_count)
  );

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush controller for the 5-stage forwarding pipeline. It detects load-use hazards that forwarding cannot cover and squashes wrong-path instructions when a branch or jump resolves in MEM. It also freezes the pipeline while a multi-cycle data memory access is outstanding. It drives write-enables and bubble/flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB, and keeps saturating stall and flush performance counters.

Parameters:
REG_W, 5, register-address width
MAX_WAIT, 15, memory-wait cycles before timeout error (≥1)
CNT_W, 16, performance counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
id_rs  in  REG_W  rs field of instruction in ID
id_rt  in  REG_W  rt field of instruction in ID
id_uses_rt  in  1  ID instruction reads rt (R-type, store, beq)
ex_mem_read  in  1  instruction in EX is a load
ex_write_reg  in  REG_W  destination register of EX instruction
mem_redirect  in  1  taken branch or jump resolved in MEM
dmem_req  in  1  MEM-stage instruction reads or writes dmem
dmem_ready  in  1  dmem completes the access this cycle
pc_write  out  1  PC load enable
ifid_write  out  1  IF/ID load enable
ifid_flush  out  1  load NOP into IF/ID
idex_bubble  out  1  zero ID/EX control bits
exmem_flush  out  1  zero EX/MEM control bits
front_hold  out  1  hold ID/EX and EX/MEM contents
mw_bubble  out  1  zero MEM/WB control bits
mem_err  out  1  sticky timeout flag
stall_count  out  CNT_W  saturating stall-cycle count
flush_count  out  CNT_W  saturating redirect count

Behaviour:
- States: RUN, MEM_WAIT, ERROR. Registers are state, wait_cnt, stall_count and flush_count. Control outputs are combinational from state and inputs.
- While rst=1: state=RUN, wait_cnt=0, both counters=0, mem_err=0. pc_write=0, ifid_write=0. ifid_flush, idex_bubble, exmem_flush and mw_bubble all =1. front_hold=0. Reset asserted mid-wait aborts the wait immediately.
- Default in RUN: pc_write=1, ifid_write=1, all other controls 0.
- load_use = ex_mem_read & (ex_write_reg != 0) & ((ex_write_reg == id_rs) | (id_uses_rt & ex_write_reg == id_rt)).
- Priority in RUN, highest first:
  - mem wait: dmem_req & !dmem_ready. Applies the hold set below. Next state=MEM_WAIT, wait_cnt=1, stall_count++.
  - redirect: mem_redirect. pc_write=1, ifid_flush=1, idex_bubble=1, exmem_flush=1, flush_count++. Any simultaneous load_use is ignored and not counted.
  - load_use: pc_write=0, ifid_write=0, idex_bubble=1, stall_count++. This is one bubble; the hazard clears the next cycle as the load enters MEM.
- Hold set: pc_write=0, ifid_write=0, front_hold=1, mw_bubble=1.
- MEM_WAIT:
  - Apply the hold set and stall_count++ each cycle.
  - On dmem_ready: release the hold set this cycle, with pc_write=1 and ifid_write=1. A pending mem_redirect is honoured this cycle as in RUN. Next state=RUN, wait_cnt=0.
  - Else if wait_cnt==MAX_WAIT: next state=ERROR.
  - Else wait_cnt++.
- ERROR: hold set applied permanently, mem_err=1, counters frozen. Only rst exits.
- dmem_req & dmem_ready in the same RUN cycle: no stall (zero-wait memory).
- Counters saturate at 2^CNT_W−1 and do not wrap.
- Latency: the hazard response is in the same cycle as the hazard inputs. State and counter updates take effect at the next rising clk.

Decomposition:
- Package pipeline_ctrl_pkg holds:
  - the state encoding (RUN=2'd0, MEM_WAIT=2'd1, ERROR=2'd2);
  - the zero-register constant;
  - the default REG_W and CNT_W values.
- One sub-module, sat_counter (parameter W; ports clk, rst, inc, clr, count), instantiated twice for stall_count and flush_count.
- Hazard compare and output decode stay in pipeline_ctrl.

Test Plan:
- Load-use: ex_mem_read=1, ex_write_reg=8, id_rs=8 → pc_write=0, ifid_write=0, idex_bubble=1 for exactly 1 cycle; stall_count 0→1. Repeat with ex_write_reg=0 → no stall.
- Redirect: mem_redirect=1 with simultaneous load_use (rt match, id_uses_rt=1) → ifid_flush, idex_bubble and exmem_flush all 1; pc_write=1; flush_count=1; stall_count unchanged.
- Memory wait: dmem_req=1, dmem_ready low for 3 cycles then high → hold set for 3 cycles, release on cycle 4, stall_count=3, state back to RUN.
- Timeout: MAX_WAIT=4, dmem_ready never asserted → ERROR after 5 hold cycles, mem_err=1 and stays 1 while inputs toggle; rst clears everything to reset values asynchronously mid-cycle.
- Saturation: CNT_W=3, 10 consecutive load-use cycles → stall_count sticks at 7.
- Zero-wait memory: dmem_req=1 and dmem_ready=1 every cycle for 5 cycles → no hold, stall_count=0, pc_write=1 throughout.
